// File: rtl/zrb_uart_rx_os8_pkg.sv
// zrb_uart_rx_os8 shared definitions.
// FSM state codes, oversample timing points and the majority-vote helper.
package zrb_uart_rx_os8_pkg;

  localparam int OVERSAMPLE = 8;
  localparam int CNT_W      = $clog2(OVERSAMPLE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] SMP1_TICK = CNT_W'(3);
  localparam logic [CNT_W-1:0] SMP2_TICK = CNT_W'(4);
  localparam logic [CNT_W-1:0] VOTE_TICK = CNT_W'(5);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);

  function automatic logic maj3(input logic a,
                                input logic b,
                                input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/zrb_uart_rx_os8_sync.sv
// zrb_sync_2ff: two-flop synchronizer for one asynchronous bit.
// RST_VAL lets an idle-high line come out of reset already idle.
module zrb_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  // two-stage metastability filter, runs every clk
  always_ff @(posedge clk) begin
    if (reset) begin
      ff1_q <= RST_VAL;
      ff2_q <= RST_VAL;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/zrb_uart_rx_os8.sv
// zrb_uart_rx_os8: 8x oversampling UART receiver, 8N1, LSB first.
// Majority vote per bit, armed false-start guard, stop-bit framing check.
module zrb_uart_rx_os8
  import zrb_uart_rx_os8_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  logic             rx_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             armed_q, armed_d;
  logic             smp1_q, smp1_d;
  logic             smp2_q, smp2_d;
  logic             vote;

  zrb_sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  assign vote = maj3(smp1_q, smp2_q, rx_s);

  // next-state: FSM and counters advance only on oversample ticks
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    armed_d = armed_q;
    smp1_d  = smp1_q;
    smp2_d  = smp2_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (clk_en) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == SMP1_TICK) smp1_d = rx_s;
      if (cnt_q == SMP2_TICK) smp2_d = rx_s;
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (armed_q && !rx_s) begin
            state_d = S_START;
            cnt_d   = CNT_W'(1);
            armed_d = 1'b0;
          end else if (rx_s) begin
            armed_d = 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == VOTE_TICK && vote) begin
            state_d = S_IDLE;
          end else if (cnt_q == LAST_TICK) begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (cnt_q == VOTE_TICK) begin
            shreg_d = {vote, shreg_q[7:1]};
          end
          if (cnt_q == LAST_TICK) begin
            if (bit_q == 3'(NUM_BITS - 1)) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (cnt_q == VOTE_TICK) begin
            state_d = S_IDLE;
            if (vote) begin
              data_d  = shreg_q >> (8 - NUM_BITS);
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
      smp1_q  <= 1'b0;
      smp2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
      smp1_q  <= smp1_d;
      smp2_q  <= smp2_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_zrb_uart_rx_os8.sv
// tb_zrb_uart_rx_os8: serializer-driven bench with a frame-level model.
// Two receivers: NUM_BITS=8 on rx, NUM_BITS=7 on rx7.
module tb_zrb_uart_rx_os8;

  typedef struct {
    bit         err;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       rx;
  logic       rx7;
  logic [7:0] data;
  logic [7:0] data7;
  logic       valid;
  logic       valid7;
  logic       frame_err;
  logic       ferr7;

  ev_t        q8[$];
  ev_t        q7[$];
  logic [7:0] m8 = 8'h00;
  logic [7:0] m7 = 8'h00;
  int         n_chk = 0;
  int         n_fail = 0;
  int         nv8 = 0;
  int         ne8 = 0;
  int         nv7 = 0;
  int         ne7 = 0;

  always #5 clk = ~clk;

  zrb_uart_rx_os8 #(.NUM_BITS(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err)
  );

  zrb_uart_rx_os8 #(.NUM_BITS(7)) dut7 (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .rx       (rx7),
    .data     (data7),
    .valid    (valid7),
    .frame_err(ferr7)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // oversample tick: one clk in four
  initial begin
    clk_en = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 clk_en = 1'b1;
      @(posedge clk);
      #1 clk_en = 1'b0;
    end
  end

  // compare DUT outputs against the frame model every cycle
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      m8 = 8'h00;
      m7 = 8'h00;
    end else begin
      chk("excl8", {31'b0, valid & frame_err}, 0);
      if (valid || frame_err) begin
        chk("expected8", {31'b0, q8.size() != 0}, 1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          chk("kind8", {31'b0, frame_err}, {31'b0, e.err});
          if (!e.err) m8 = e.d;
          if (valid) nv8++;
          if (frame_err) ne8++;
        end
      end
      chk("data8", {24'b0, data}, {24'b0, m8});
      chk("excl7", {31'b0, valid7 & ferr7}, 0);
      if (valid7 || ferr7) begin
        chk("expected7", {31'b0, q7.size() != 0}, 1);
        if (q7.size() != 0) begin
          e = q7.pop_front();
          chk("kind7", {31'b0, ferr7}, {31'b0, e.err});
          if (!e.err) m7 = e.d;
          if (valid7) nv7++;
          if (ferr7) ne7++;
        end
      end
      chk("data7", {24'b0, data7}, {24'b0, m7});
    end
  end

  task automatic drive(input bit sel7, input logic v);
    if (sel7) rx7 = v;
    else rx = v;
  endtask

  task automatic hold(input bit sel7, input logic v, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1 drive(sel7, v);
    end
  endtask

  // frame k=0 start, k=1..nb data, k=nb+1 stop; 32 clk per bit
  task automatic send(input bit sel7, input logic [7:0] b,
                      input int nb, input bit stop_ok,
                      input int gbit, input int goff);
    ev_t  e;
    logic v;
    e.err = !stop_ok;
    e.d   = b & 8'((1 << nb) - 1);
    if (sel7) q7.push_back(e);
    else q8.push_back(e);
    for (int k = 0; k < nb + 2; k++) begin
      if (k == 0) v = 1'b0;
      else if (k == nb + 1) v = stop_ok;
      else v = b[k-1];
      for (int c = 0; c < 32; c++) begin
        @(posedge clk);
        #1;
        if (k == gbit && c >= goff && c < goff + 4) drive(sel7, ~v);
        else drive(sel7, v);
      end
    end
    if (sel7) chk("drain7", q7.size(), 0);
    else chk("drain8", q8.size(), 0);
  endtask

  initial begin
    int          v0;
    int          e0;
    logic [7:0]  b;
    logic [7:0]  tmp;
    bit          ok;
    int          gb;
    reset = 1'b1;
    rx    = 1'b1;
    rx7   = 1'b1;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst data", {24'b0, data}, 32'h00);
    chk("rst valid", {31'b0, valid}, 0);
    chk("rst ferr", {31'b0, frame_err}, 0);
    chk("rst data7", {24'b0, data7}, 32'h00);
    hold(0, 1'b1, 40);

    // single byte
    v0 = nv8; e0 = ne8;
    send(0, 8'hA5, 8, 1, -1, 0);
    chk("t1 data", {24'b0, data}, 32'hA5);
    chk("t1 nvalid", nv8 - v0, 1);
    chk("t1 nerr", ne8 - e0, 0);
    hold(0, 1'b1, 20);

    // back-to-back frames
    v0 = nv8;
    send(0, 8'h00, 8, 1, -1, 0);
    send(0, 8'hFF, 8, 1, -1, 0);
    send(0, 8'h55, 8, 1, -1, 0);
    chk("t2 data", {24'b0, data}, 32'h55);
    chk("t2 nvalid", nv8 - v0, 3);

    // short low pulse is rejected
    v0 = nv8; e0 = ne8;
    hold(0, 1'b1, 20);
    hold(0, 1'b0, 8);
    hold(0, 1'b1, 60);
    chk("t3 nvalid", nv8 - v0, 0);
    chk("t3 nerr", ne8 - e0, 0);

    // bad stop bit, then good frame
    v0 = nv8; e0 = ne8;
    send(0, 8'h3C, 8, 0, -1, 0);
    chk("t4 nerr", ne8 - e0, 1);
    chk("t4 data held", {24'b0, data}, 32'h55);
    hold(0, 1'b1, 40);
    send(0, 8'h81, 8, 1, -1, 0);
    chk("t4 data", {24'b0, data}, 32'h81);
    chk("t4 nvalid", nv8 - v0, 1);

    // one corrupted sample inside data bit 2
    hold(0, 1'b1, 10);
    send(0, 8'hF0, 8, 1, 3, 16);
    chk("t5 data", {24'b0, data}, 32'hF0);

    // reset in the middle of bit 3 of 0x12, line then stuck low
    hold(0, 1'b1, 23);
    b = 8'h12;
    hold(0, 1'b0, 32);
    for (int k = 0; k < 3; k++) hold(0, b[k], 32);
    hold(0, b[3], 16);
    reset = 1'b1;
    hold(0, 1'b0, 8);
    while (clk_en !== 1'b1) begin
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6 rst data", {24'b0, data}, 32'h00);
    v0 = nv8; e0 = ne8;
    hold(0, 1'b0, 120);
    chk("t6 low nvalid", nv8 - v0, 0);
    chk("t6 low nerr", ne8 - e0, 0);
    hold(0, 1'b1, 64);
    send(0, 8'h12, 8, 1, -1, 0);
    chk("t6 data", {24'b0, data}, 32'h12);

    // seven data bits
    hold(1, 1'b1, 30);
    send(1, 8'h7F, 7, 1, -1, 0);
    chk("t7 data7", {24'b0, data7}, 32'h7F);
    chk("t7 nvalid7", nv7, 1);

    // randomized traffic on the 8-bit receiver
    for (int i = 0; i < 40; i++) begin
      tmp = 8'($urandom);
      ok  = ($urandom_range(0, 5) != 0);
      gb  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : -1;
      send(0, tmp, 8, ok, gb, $urandom_range(4, 24));
      if ($urandom_range(0, 7) == 0) begin
        hold(0, 1'b1, 12);
        hold(0, 1'b0, $urandom_range(3, 8));
        hold(0, 1'b1, 40);
      end
      hold(0, 1'b1, ok ? $urandom_range(0, 40) : $urandom_range(8, 40));
    end

    // randomized traffic on the 7-bit receiver
    for (int i = 0; i < 12; i++) begin
      tmp = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      gb  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : -1;
      send(1, tmp, 7, ok, gb, $urandom_range(4, 24));
      hold(1, 1'b1, ok ? $urandom_range(0, 30) : $urandom_range(8, 30));
    end

    hold(0, 1'b1, 60);
    chk("end q8", q8.size(), 0);
    chk("end q7", q7.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
